// File: rtl/tdm_demux_pkg.sv
// ---------------------------------------------------------------------------
// tdm_demux_pkg
// Shared definitions for the TDM demultiplexer:
//   NUM_SLOTS  - data slots per frame (4)
//   SLOT_W     - width of the slot index (2)
//   slot_t     - slot index type
//   LAST_SLOT  - index of the final data slot in a frame
//   state_t    - FSM encoding: HUNT, RUN, and PARITY (PARITY only when
//                TDM_PARITY_EN is defined)
// ---------------------------------------------------------------------------
package tdm_demux_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

`ifdef TDM_PARITY_EN
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        RUN    = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        HUNT = 2'd0,
        RUN  = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/tdm_slot_counter.sv
// ---------------------------------------------------------------------------
// tdm_slot_counter
// Slot index for the TDM demultiplexer. Holds the index of the slot the
// next data cycle is expected to carry.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset, clears the index
//   clr   - force index to 0
//   load1 - force index to 1 (slot 0 has just been captured)
//   inc   - advance index, wrapping from LAST_SLOT back to 0
//   slot  - current slot index
// Priority: clr > load1 > inc.
// ---------------------------------------------------------------------------
module tdm_slot_counter
    import tdm_demux_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  load1,
    input  logic  inc,
    output slot_t slot
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else if (clr) begin
            slot <= '0;
        end else if (load1) begin
            slot <= slot_t'(1);
        end else if (inc) begin
            // NUM_SLOTS is a power of two, so natural overflow is the wrap.
            slot <= slot + slot_t'(1);
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// ---------------------------------------------------------------------------
// tdm_demux
// Serial TDM demultiplexer. Each clock carries one slot of a 4-slot frame;
// sync marks slot 0. Slots are gathered in a shadow register and copied to
// the W outputs only once a complete (and, optionally, parity-correct)
// frame has arrived, so the W outputs never show a partial frame.
// Optional feature: define TDM_PARITY_EN to append an even-parity bit to
// each frame (5 cycles per frame) and enable the parity_err output.
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous active-high reset
//   din         - serial data, one slot per clock
//   sync        - frame marker, high with slot 0
//   W0..W3      - registered channel outputs, slot 0..3
//   S1,S0       - index of the slot expected in the next data cycle
//   frame_valid - one-cycle pulse when W3..W0 update
//   sync_err    - one-cycle pulse on a framing violation
//   parity_err  - one-cycle pulse on a bad parity bit (TDM_PARITY_EN only)
// ---------------------------------------------------------------------------
module tdm_demux
    import tdm_demux_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic sync,
    output logic W0,
    output logic W1,
    output logic W2,
    output logic W3,
    output logic S1,
    output logic S0,
    output logic frame_valid,
`ifdef TDM_PARITY_EN
    output logic parity_err,
`endif
    output logic sync_err
);

    state_t                 state;
    state_t                 state_nxt;
    slot_t                  slot;
    logic [NUM_SLOTS-1:0]   shadow;
    logic [NUM_SLOTS-1:0]   w_reg;
    logic [NUM_SLOTS-1:0]   w_src;

    // Control strobes produced by the FSM output logic.
    logic cnt_clr;
    logic cnt_ld1;
    logic cnt_inc;
    logic cap;        // store din into shadow[slot]
    logic restart;    // start a new frame with din as slot 0
    logic ld_w;       // copy the finished frame to the W outputs
    logic fv_set;
    logic serr_set;
    logic perr_set;

    tdm_slot_counter u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .load1 (cnt_ld1),
        .inc   (cnt_inc),
        .slot  (slot)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            HUNT: begin
                if (sync) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (slot == '0 && !sync) begin
                    state_nxt = HUNT;
                end
`ifdef TDM_PARITY_EN
                else if (slot == LAST_SLOT && !sync) begin
                    state_nxt = PARITY;
                end
            end
            PARITY: begin
                state_nxt = RUN;
            end
`else
            end
`endif
            default: state_nxt = HUNT;
        endcase
    end

    // Output / control logic.
    always_comb begin
        cnt_clr  = 1'b0;
        cnt_ld1  = 1'b0;
        cnt_inc  = 1'b0;
        cap      = 1'b0;
        restart  = 1'b0;
        ld_w     = 1'b0;
        fv_set   = 1'b0;
        serr_set = 1'b0;
        perr_set = 1'b0;
        case (state)
            HUNT: begin
                // din is ignored until sync; no error is possible here.
                if (sync) begin
                    restart = 1'b1;
                    cnt_ld1 = 1'b1;
                end
            end
            RUN: begin
                if (slot == '0) begin
                    if (sync) begin
                        restart = 1'b1;
                        cnt_ld1 = 1'b1;
                    end else begin
                        serr_set = 1'b1;
                        cnt_clr  = 1'b1;
                    end
                end else if (sync) begin
                    // Early sync: drop the partial frame and resynchronise.
                    serr_set = 1'b1;
                    restart  = 1'b1;
                    cnt_ld1  = 1'b1;
                end else begin
                    cap     = 1'b1;
                    cnt_inc = 1'b1;
`ifndef TDM_PARITY_EN
                    if (slot == LAST_SLOT) begin
                        ld_w   = 1'b1;
                        fv_set = 1'b1;
                    end
`endif
                end
            end
`ifdef TDM_PARITY_EN
            PARITY: begin
                if (sync) begin
                    serr_set = 1'b1;
                    restart  = 1'b1;
                    cnt_ld1  = 1'b1;
                end else if (din == ^shadow) begin
                    // Even parity: data bits plus parity bit XOR to zero.
                    ld_w   = 1'b1;
                    fv_set = 1'b1;
                end else begin
                    perr_set = 1'b1;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    // Without parity the last slot is still on din when the frame completes,
    // so it bypasses the shadow on its way to the outputs.
`ifdef TDM_PARITY_EN
    assign w_src = shadow;
`else
    assign w_src = {din, shadow[NUM_SLOTS-2:0]};
`endif

    // Shadow and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            w_reg       <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            if (restart) begin
                shadow <= {{(NUM_SLOTS-1){1'b0}}, din};
            end else if (cap) begin
                shadow[slot] <= din;
            end
            if (ld_w) begin
                w_reg <= w_src;
            end
            frame_valid <= fv_set;
            sync_err    <= serr_set;
        end
    end

`ifdef TDM_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= perr_set;
        end
    end
`else
    // perr_set is only meaningful with parity enabled.
    logic unused_perr;
    assign unused_perr = perr_set;
`endif

    assign W0 = w_reg[0];
    assign W1 = w_reg[1];
    assign W2 = w_reg[2];
    assign W3 = w_reg[3];
    assign S1 = slot[1];
    assign S0 = slot[0];

endmodule
